// File: rtl/jtopl_eg_sched.sv
// jtopl_eg_sched: per-slot operator parameter file, slot sequencer and result capture.
// Define JTOPL_EG_SCHED_SILENT_EN to add the per-slot silent flag output.
module jtopl_eg_sched #(
  parameter int SLOTS = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             wr_en,
  input  logic [4:0]       wr_slot,
  input  logic [1:0]       wr_sel,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic [5:0]       tl,
  output logic [1:0]       ksl,
  output logic [3:0]       fnum,
  output logic [2:0]       block,
  output logic             amsen,
  output logic [4:0]       cur_slot,
  output logic             frame_start,
  input  logic [9:0]       eg_limited,
`ifdef JTOPL_EG_SCHED_SILENT_EN
  output logic [SLOTS-1:0] silent,
`endif
  output logic [9:0]       eg_out,
  output logic [4:0]       out_slot,
  output logic             out_valid
);

  // state    | meaning
  // WB_EMPTY | no write pending, wr_ready high
  // WB_FULL  | write held; commits unless its slot is being loaded this edge
  typedef enum logic {WB_EMPTY, WB_FULL} wb_state_t;

  localparam logic [4:0] LAST = 5'(SLOTS - 1);

  wb_state_t  r_state, w_state_nxt;
  logic [4:0] r_buf_slot;
  logic [1:0] r_buf_sel;
  logic [7:0] r_buf_data;
  logic       w_accept, w_commit, w_ready, w_buf_hit;

  logic [5:0] r_tl_f   [SLOTS];
  logic [1:0] r_ksl_f  [SLOTS];
  logic [3:0] r_fnum_f [SLOTS];
  logic [2:0] r_blk_f  [SLOTS];
  logic       r_ams_f  [SLOTS];

  logic [4:0] r_cur_slot, w_next_slot, r_out_slot;
  logic [5:0] r_tl;
  logic [1:0] r_ksl;
  logic [3:0] r_fnum;
  logic [2:0] r_blk;
  logic       r_ams, r_frame_start, r_out_valid;
  logic [9:0] r_eg_out;

  assign w_next_slot = (r_cur_slot == LAST) ? 5'd0 : r_cur_slot + 5'd1;
  assign w_buf_hit   = ({1'b0, r_buf_slot} < 6'(SLOTS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WB_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_EMPTY: if (wr_en)    w_state_nxt = WB_FULL;
      WB_FULL:  if (w_commit) w_state_nxt = WB_EMPTY;
      default:                w_state_nxt = WB_EMPTY;
    endcase
  end

  always_comb begin
    w_ready  = (r_state == WB_EMPTY);
    w_accept = w_ready & wr_en;
    w_commit = (r_state == WB_FULL) & ~(cen & (r_buf_slot == w_next_slot));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_slot <= '0;
      r_buf_sel  <= '0;
      r_buf_data <= '0;
    end else if (w_accept) begin
      r_buf_slot <= wr_slot;
      r_buf_sel  <= wr_sel;
      r_buf_data <= wr_data;
    end
  end

  // Out-of-range slots and field select 3 drain the buffer without touching the file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_tl_f[i]   <= '0;
        r_ksl_f[i]  <= '0;
        r_fnum_f[i] <= '0;
        r_blk_f[i]  <= '0;
        r_ams_f[i]  <= 1'b0;
      end
    end else if (w_commit && w_buf_hit) begin
      case (r_buf_sel)
        2'd0: begin
          r_ksl_f[r_buf_slot] <= r_buf_data[7:6];
          r_tl_f[r_buf_slot]  <= r_buf_data[5:0];
        end
        2'd1: begin
          r_blk_f[r_buf_slot]  <= r_buf_data[6:4];
          r_fnum_f[r_buf_slot] <= r_buf_data[3:0];
        end
        2'd2:    r_ams_f[r_buf_slot] <= r_buf_data[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_slot    <= LAST;
      r_tl          <= '0;
      r_ksl         <= '0;
      r_fnum        <= '0;
      r_blk         <= '0;
      r_ams         <= 1'b0;
      r_frame_start <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_slot    <= '0;
      r_eg_out      <= 10'h3FF;
    end else begin
      r_frame_start <= cen && (w_next_slot == 5'd0);
      r_out_valid   <= cen;
      if (cen) begin
        r_cur_slot <= w_next_slot;
        r_tl       <= r_tl_f[w_next_slot];
        r_ksl      <= r_ksl_f[w_next_slot];
        r_fnum     <= r_fnum_f[w_next_slot];
        r_blk      <= r_blk_f[w_next_slot];
        r_ams      <= r_ams_f[w_next_slot];
        r_out_slot <= r_cur_slot;
        r_eg_out   <= eg_limited;
      end
    end
  end

`ifdef JTOPL_EG_SCHED_SILENT_EN
  logic [SLOTS-1:0] r_silent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_silent <= '1;
    else if (cen) r_silent[r_cur_slot] <= (eg_limited == 10'h3FF);
  end

  assign silent = r_silent;
`endif

  assign wr_ready    = w_ready;
  assign tl          = r_tl;
  assign ksl         = r_ksl;
  assign fnum        = r_fnum;
  assign block       = r_blk;
  assign amsen       = r_ams;
  assign cur_slot    = r_cur_slot;
  assign frame_start = r_frame_start;
  assign eg_out      = r_eg_out;
  assign out_slot    = r_out_slot;
  assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_jtopl_eg_sched.sv
// Directed bench for jtopl_eg_sched: sequencing, write buffering/deferral, capture and reset.
module tb_jtopl_eg_sched;
  localparam int SLOTS = 18;

  logic       clk = 1'b0;
  logic       rst_n, cen, wr_en;
  logic [4:0] wr_slot;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [5:0] tl;
  logic [1:0] ksl;
  logic [3:0] fnum;
  logic [2:0] block;
  logic       amsen;
  logic [4:0] cur_slot;
  logic       frame_start;
  logic [9:0] eg_limited;
  logic [9:0] eg_out;
  logic [4:0] out_slot;
  logic       out_valid;
`ifdef JTOPL_EG_SCHED_SILENT_EN
  logic [SLOTS-1:0] silent;
`endif

  jtopl_eg_sched #(.SLOTS(SLOTS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .wr_en       (wr_en),
    .wr_slot     (wr_slot),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .tl          (tl),
    .ksl         (ksl),
    .fnum        (fnum),
    .block       (block),
    .amsen       (amsen),
    .cur_slot    (cur_slot),
    .frame_start (frame_start),
    .eg_limited  (eg_limited),
`ifdef JTOPL_EG_SCHED_SILENT_EN
    .silent      (silent),
`endif
    .eg_out      (eg_out),
    .out_slot    (out_slot),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_slot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic c);
    cen = c;
    @(posedge clk); #1;
    cen = 1'b0;
    if (c) exp_slot = (exp_slot + 1) % SLOTS;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      chk("cur_slot",    32'(cur_slot),    32'(exp_slot));
      chk("frame_start", 32'(frame_start), 32'(exp_slot == 0));
      chk("out_valid",   32'(out_valid),   32'd1);
    end
  endtask

  task automatic wr_idle(input logic [4:0] s, input logic [1:0] f, input logic [7:0] d);
    wr_en = 1'b1; wr_slot = s; wr_sel = f; wr_data = d;
    step(1'b0);
    wr_en = 1'b0;
    chk("wr_ready_busy", 32'(wr_ready), 32'd0);
    step(1'b0);
    chk("wr_ready_back", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b0; wr_en = 1'b0; wr_slot = '0; wr_sel = '0; wr_data = '0;
    eg_limited = '0;
    exp_slot = SLOTS - 1;
    #12;
    chk("rst_cur_slot",    32'(cur_slot),    32'd17);
    chk("rst_eg_out",      32'(eg_out),      32'h3FF);
    chk("rst_wr_ready",    32'(wr_ready),    32'd1);
    chk("rst_out_valid",   32'(out_valid),   32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_out_slot",    32'(out_slot),    32'd0);
    chk("rst_tl",          32'(tl),          32'd0);
`ifdef JTOPL_EG_SCHED_SILENT_EN
    chk("rst_silent",      32'(silent),      32'h3FFFF);
`endif
    #11 rst_n = 1'b1;

    // Frame 1: first pulse presents slot 0, then freeze with cen low
    adv(1);
    chk("out_slot_first", 32'(out_slot), 32'd17);
    step(1'b0);
    chk("freeze_slot",  32'(cur_slot),    32'd0);
    chk("freeze_fs",    32'(frame_start), 32'd0);
    chk("freeze_valid", 32'(out_valid),   32'd0);
    adv(2);
    wr_idle(5'd5, 2'd0, 8'hC3);
    adv(2);
    chk("tl_slot4", 32'(tl), 32'd0);
    adv(1);
    chk("tl_slot5",  32'(tl),  32'h03);
    chk("ksl_slot5", 32'(ksl), 32'd3);
    adv(4);
    eg_limited = 10'h123;
    adv(1);
    eg_limited = 10'h000;
    chk("eg_out_cap",   32'(eg_out),   32'h123);
    chk("out_slot_cap", 32'(out_slot), 32'd9);
    step(1'b0);
    chk("valid_1clk",   32'(out_valid), 32'd0);
    chk("eg_out_hold",  32'(eg_out),    32'h123);
    chk("out_slot_hold",32'(out_slot),  32'd9);
    chk("slot_hold",    32'(cur_slot),  32'd10);
`ifdef JTOPL_EG_SCHED_SILENT_EN
    chk("silent9", 32'(silent[9]), 32'd0);
`endif
    adv(7);
    adv(1);  // 19th pulse wraps 17 -> 0

    // Frame 2: write to slot 6 that collides with its own load edge
    adv(4);
    wr_en = 1'b1; wr_slot = 5'd6; wr_sel = 2'd1; wr_data = 8'h5A;
    adv(1);
    wr_en = 1'b0;
    chk("tl_slot5_f2", 32'(tl),       32'h03);
    chk("wr_busy_f2",  32'(wr_ready), 32'd0);
    adv(1);
    chk("wr_deferred",  32'(wr_ready), 32'd0);
    chk("fnum_old",     32'(fnum),     32'd0);
    chk("block_old",    32'(block),    32'd0);
    step(1'b0);
    chk("wr_done",      32'(wr_ready), 32'd1);
    chk("fnum_held",    32'(fnum),     32'd0);
    chk("block_held",   32'(block),    32'd0);
    wr_idle(5'd4,  2'd2, 8'h01);
    wr_idle(5'd5,  2'd3, 8'hFF);
    wr_idle(5'd20, 2'd1, 8'hFF);
    adv(11);
    adv(1);

    // Frame 3: verify committed values
    adv(4);
    chk("amsen_slot4", 32'(amsen), 32'd1);
    chk("tl_slot4_f3", 32'(tl),    32'd0);
    adv(1);
    chk("tl_sel3",    32'(tl),    32'h03);
    chk("ksl_sel3",   32'(ksl),   32'd3);
    chk("fnum_sel3",  32'(fnum),  32'd0);
    chk("amsen_s5",   32'(amsen), 32'd0);
    wr_en = 1'b1; wr_slot = 5'd12; wr_sel = 2'd0; wr_data = 8'h3F;
    adv(1);
    wr_en = 1'b0;
    chk("block_new",   32'(block),    32'd5);
    chk("fnum_new",    32'(fnum),     32'hA);
    chk("tl_slot6",    32'(tl),       32'd0);
    chk("wr_pending",  32'(wr_ready), 32'd0);

    // Reset with a write pending and cen active
    cen = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("mrst_eg_out",   32'(eg_out),      32'h3FF);
    chk("mrst_wr_ready", 32'(wr_ready),    32'd1);
    chk("mrst_cur_slot", 32'(cur_slot),    32'd17);
    chk("mrst_block",    32'(block),       32'd0);
    chk("mrst_fnum",     32'(fnum),        32'd0);
    chk("mrst_valid",    32'(out_valid),   32'd0);
    chk("mrst_out_slot", 32'(out_slot),    32'd0);
`ifdef JTOPL_EG_SCHED_SILENT_EN
    chk("mrst_silent",   32'(silent),      32'h3FFFF);
`endif
    #2 rst_n = 1'b1;
    exp_slot = SLOTS - 1;
    adv(1);
    adv(4);
    chk("clr_amsen4", 32'(amsen), 32'd0);
    adv(1);
    chk("clr_tl5",    32'(tl),    32'd0);
    adv(1);
    chk("clr_block6", 32'(block), 32'd0);
    adv(6);
    chk("lost_tl12",  32'(tl),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
